// File: rtl/ram_bus_pkg.sv
// Shared types and defaults for the RAM bus initiator.
package ram_bus_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    // Controller state; each state maps directly onto one RAM bus phase.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_TURN  = 2'd3
    } state_e;

    // Direction of the most recent bus operation, used to decide on turnaround.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_RD   = 2'd1,
        DIR_WR   = 2'd2
    } dir_e;

    // Map a request's write flag onto a bus direction.
    function automatic dir_e dir_of(input logic is_write);
        return is_write ? DIR_WR : DIR_RD;
    endfunction

    // A turnaround cycle is needed only when the bus changes direction.
    function automatic logic needs_turn(input dir_e last_dir, input dir_e next_dir);
        return (last_dir != DIR_NONE) && (last_dir != next_dir);
    endfunction

endpackage

// File: rtl/ram_bus_master.sv
// RAM bus initiator: turns single-beat valid/ready requests into RAM cycles,
// inserts a one-cycle bus turnaround on direction changes and returns read
// data on a one-cycle response strobe.
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    state_e                  state_q, state_d;
    dir_e                    dir_q, dir_d;
    logic                    pend_q, pend_d;
    logic                    pend_write_q, pend_write_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0]   pend_wdata_q, pend_wdata_d;
    logic                    ready_q, ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_dout_q, mem_dout_d;
    logic                    mem_cs_q, mem_cs_d;
    logic                    mem_we_q, mem_we_d;
    logic                    mem_oe_q, mem_oe_d;

    logic                    accept_s;
    logic                    issue_s;
    logic                    issue_write_s;
    logic [ADDR_WIDTH-1:0]   issue_addr_s;
    logic [DATA_WIDTH-1:0]   issue_wdata_s;

    // The data bus is driven only while a WRITE cycle is on the bus.
    assign mem_data  = mem_we_q ? mem_dout_q : {DATA_WIDTH{1'bz}};

    assign req_ready = ready_q & rst_n;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_oe    = mem_oe_q;

    // Next-state, request issue and output decode for the bus sequencer.
    always_comb begin
        accept_s      = req_valid & ready_q;
        state_d       = ST_IDLE;
        dir_d         = dir_q;
        pend_d        = pend_q;
        pend_write_d  = pend_write_q;
        pend_addr_d   = pend_addr_q;
        pend_wdata_d  = pend_wdata_q;
        mem_addr_d    = mem_addr_q;
        mem_dout_d    = mem_dout_q;
        issue_s       = 1'b0;
        issue_write_s = 1'b0;
        issue_addr_s  = pend_addr_q;
        issue_wdata_s = pend_wdata_q;

        // Read data is valid at the edge that closes the READ cycle.
        if (state_q == ST_READ) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_data;
        end else begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = rsp_rdata_q;
        end

        case (state_q)
            ST_TURN: begin
                // Bus has been idle for one cycle; launch the held request.
                issue_s       = 1'b1;
                issue_write_s = pend_write_q;
                issue_addr_s  = pend_addr_q;
                issue_wdata_s = pend_wdata_q;
                pend_d        = 1'b0;
            end
            ST_IDLE, ST_WRITE, ST_READ: begin
                if (accept_s) begin
                    if (needs_turn(dir_q, dir_of(req_write))) begin
                        state_d      = ST_TURN;
                        pend_d       = 1'b1;
                        pend_write_d = req_write;
                        pend_addr_d  = req_addr;
                        pend_wdata_d = req_wdata;
                    end else begin
                        issue_s       = 1'b1;
                        issue_write_s = req_write;
                        issue_addr_s  = req_addr;
                        issue_wdata_s = req_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue_s) begin
            state_d    = issue_write_s ? ST_WRITE : ST_READ;
            dir_d      = dir_of(issue_write_s);
            mem_addr_d = issue_addr_s;
            mem_dout_d = issue_write_s ? issue_wdata_s : mem_dout_q;
        end else begin
            mem_addr_d = mem_addr_q;
            mem_dout_d = mem_dout_q;
        end

        mem_cs_d = (state_d == ST_WRITE) || (state_d == ST_READ);
        mem_we_d = (state_d == ST_WRITE);
        mem_oe_d = (state_d == ST_READ);
        ready_d  = (state_d != ST_TURN) && !pend_d;
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_NONE;
            pend_q       <= 1'b0;
            pend_write_q <= 1'b0;
            pend_addr_q  <= {ADDR_WIDTH{1'b0}};
            pend_wdata_q <= {DATA_WIDTH{1'b0}};
            ready_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= {DATA_WIDTH{1'b0}};
            mem_addr_q   <= {ADDR_WIDTH{1'b0}};
            mem_dout_q   <= {DATA_WIDTH{1'b0}};
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_oe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            pend_write_q <= pend_write_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            ready_q      <= ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_dout_q   <= mem_dout_d;
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_oe_q     <= mem_oe_d;
        end
    end

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: drives requests, models the RAM responder and
// checks bus cycles and read responses against a simple array model.
module tb_ram_bus_master;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;

    ram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM responder: commits writes at posedge, updates output at negedge.
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] ram_dout;
    wire           ram_drive = mem_cs & mem_oe;
    assign mem_data = ram_drive ? ram_dout : 8'hzz;

    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    end

    always @(negedge clk) begin
        if (mem_cs && mem_oe) ram_dout <= ram[mem_addr];
    end

    // Reference model and scoreboard state.
    typedef struct { bit wr; int addr; int data; } op_t;
    typedef struct { int data; int cyc; } rsp_t;
    op_t      exp_ops[$];
    rsp_t     exp_rsp[$];
    bit [7:0] ref_mem [1024];
    int       last_dir;   // 0 none, 1 read, 2 write
    bit       prev_turn;
    int       errors = 0;
    int       checks = 0;
    int       cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: protocol rules, bus cycles and read responses.
    always @(negedge clk) begin
        chk("we_oe_exclusive", int'(mem_we & mem_oe), 0);
        chk("bus_contention", int'(mem_we & ram_drive), 0);
        if (mem_cs) begin
            if (exp_ops.size() == 0) begin
                chk("unexpected_mem_cycle", 1, 0);
            end else begin
                op_t o;
                o = exp_ops.pop_front();
                chk("mem_we", int'(mem_we), int'(o.wr));
                chk("mem_oe", int'(mem_oe), int'(!o.wr));
                chk("mem_addr", int'(mem_addr), o.addr);
                if (o.wr) chk("mem_wdata", int'(mem_data), o.data);
            end
        end
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_rsp_valid", 1, 0);
            end else begin
                rsp_t r;
                r = exp_rsp.pop_front();
                chk("rsp_rdata", int'(rsp_rdata), r.data);
                chk("rsp_latency_cycle", cyc, r.cyc);
            end
        end
    end

    // Present one request, wait for acceptance, update the model.
    task automatic do_req(input bit wr, input int addr, input int data);
        int waits;
        int dir;
        bit turn;
        int acc;
        waits = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr[AW-1:0];
        req_wdata = data[DW-1:0];
        while (!req_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) begin
            chk("accept_timeout", 1, 0);
            req_valid = 1'b0;
            return;
        end
        chk("req_ready_waits", waits, prev_turn ? 1 : 0);
        acc  = cyc;
        dir  = wr ? 2 : 1;
        turn = (last_dir != 0) && (last_dir != dir);
        last_dir = dir;
        if (wr) begin
            ref_mem[addr] = data[7:0];
            exp_ops.push_back('{wr: 1'b1, addr: addr, data: data & 255});
        end else begin
            exp_ops.push_back('{wr: 1'b0, addr: addr, data: 0});
            exp_rsp.push_back('{data: int'(ref_mem[addr]), cyc: acc + (turn ? 3 : 2)});
        end
        prev_turn = turn;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            prev_turn = 1'b0;
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ready"}, int'(req_ready), 0);
        chk({tag, "_cs"}, int'(mem_cs), 0);
        chk({tag, "_we"}, int'(mem_we), 0);
        chk({tag, "_oe"}, int'(mem_oe), 0);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        ram_dout  = 8'h00;
        last_dir  = 0;
        prev_turn = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 10'h3A5;
        req_wdata = 8'hC7;

        // Reset held with a request pending on the port.
        repeat (3) begin
            @(negedge clk);
            check_quiet("reset");
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(req_ready), 1);

        // Write then read with turnaround.
        do_req(1'b1, 10'h3A5, 8'hC7);
        do_req(1'b0, 10'h3A5, 0);
        idle(4);

        // Streamed writes then streamed reads.
        for (int i = 0; i < 4; i++) do_req(1'b1, i, 8'h10 + i);
        for (int i = 0; i < 4; i++) do_req(1'b0, i, 0);
        idle(4);

        // Alternating directions on one address.
        do_req(1'b0, 5, 0);
        do_req(1'b1, 5, 8'hAA);
        do_req(1'b0, 5, 0);
        idle(4);

        // Reset while a read is held in turnaround.
        do_req(1'b1, 7, 8'h5C);
        do_req(1'b0, 7, 0);
        @(negedge clk);
        chk("turn_cs_low", int'(mem_cs), 0);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        void'(exp_ops.pop_back());
        void'(exp_rsp.pop_back());
        last_dir  = 0;
        prev_turn = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_quiet("midreset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", int'(req_ready), 1);
        do_req(1'b0, 7, 0);
        idle(4);

        // Address boundaries.
        do_req(1'b1, 10'h3FF, 8'hFF);
        do_req(1'b1, 10'h000, 8'h00);
        do_req(1'b0, 10'h3FF, 0);
        do_req(1'b0, 10'h000, 0);
        idle(4);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            int sel;
            int a;
            sel = $urandom_range(0, 9);
            a = (sel == 0) ? 0 : (sel == 1) ? 1023 : $urandom_range(0, 15);
            do_req($urandom_range(0, 1) == 1, a, $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(6);

        chk("ops_drained", exp_ops.size(), 0);
        chk("rsp_drained", exp_rsp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
Initiator-side controller that drives the single-port synchronous RAM bus (addr, bidirectional data, chip select, write enable, output enable) on behalf of a simple valid/ready request port. It converts single-beat read/write requests into correctly timed RAM cycles and manages tri-state ownership of the shared data bus. Read data returns on a response strobe. Sits between the CPU/datapath and the RAM instance.

Parameters:
ADDR_WIDTH, 10, RAM address width in bits.
DATA_WIDTH, 8, RAM word width in bits.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  reset; synchronous, active-low.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request this cycle.
req_write  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  request address.
req_wdata  input  DATA_WIDTH  write data.
rsp_valid  output  1  one-cycle strobe: rsp_rdata holds read data.
rsp_rdata  output  DATA_WIDTH  captured read data.
mem_addr  output  ADDR_WIDTH  RAM address.
mem_data  inout  DATA_WIDTH  RAM data bus; driven only during WRITE, else high-Z.
mem_cs  output  1  RAM chip select.
mem_we  output  1  RAM write enable.
mem_oe  output  1  RAM output enable.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous, active-low (rst_n sampled on posedge clk only).
- States: IDLE, WRITE, READ, TURN. All mem_* controls are registered outputs decoded from state.
- Reset values: state IDLE, req_ready 0 while rst_n low, rsp_valid 0, rsp_rdata 0, mem_addr 0, mem_cs/mem_we/mem_oe 0, mem_data high-Z, pending request cleared, last-direction NONE.
- Handshake: request accepted at posedge where req_valid & req_ready. Accepted addr/wdata/write are registered. req_ready = 1 in IDLE, READ and WRITE with no pending request; 0 in TURN and whenever a request is held pending.
- Issue: if accepted request has same direction as last-direction, or last-direction is NONE, the next state is the op (READ/WRITE), so memory controls are active in the cycle right after acceptance. If the direction differs, the next state is TURN for exactly one cycle (cs/we/oe 0, bus high-Z), then the op. During TURN the request is held pending.
- WRITE cycle: mem_cs=1, mem_we=1, mem_oe=0, mem_data driven with wdata, mem_addr=addr. The RAM commits at the closing posedge.
- READ cycle: mem_cs=1, mem_we=0, mem_oe=1, bus released. The RAM updates its output on the mid-cycle negedge. The controller samples mem_data at the closing posedge into rsp_rdata and asserts rsp_valid for the following cycle only. Read latency from acceptance to rsp_valid is 2 cycles, or 3 with TURN.
- Throughput: same-direction requests held valid sustain 1 op per cycle. Reads pipeline: rsp_valid for read k coincides with the READ cycle of read k+1.
- No response back-pressure: the consumer must take rsp_rdata when rsp_valid=1.
- Bus ownership: the controller never drives mem_data in any state but WRITE. mem_oe and mem_we are never both 1.
- No request → return to IDLE with all controls 0. last-direction is retained through IDLE.
- Reset mid-operation: the next posedge forces reset values and drops any pending or TURN-held request. No rsp_valid is produced for it. A WRITE already presented at the reset posedge commits in the RAM; this is accepted behaviour.
- Addresses 0 and 2^ADDR_WIDTH-1 are valid. No wrap logic; the address passes through unchanged.

Decomposition:
- Package ram_bus_pkg: state enum (IDLE, WRITE, READ, TURN), direction enum (NONE, RD, WR), default width constants.
- Single module. No sub-module needed: the tri-state driver is a single conditional assign.
- The bench instantiates the existing RAM as the responder.

Test Plan:
- Reset: rst_n=0 for 3 cycles with req_valid=1 → req_ready=0, mem_cs/we/oe=0, mem_data=Z, rsp_valid=0. After release, req_ready=1 next cycle.
- Write 0x3A5←0xC7, then read 0x3A5 → WRITE cycle, one TURN cycle, READ cycle. rsp_valid pulses once with rsp_rdata=0xC7, 3 cycles after read acceptance.
- Writes addr 0..3 with data 0x10..0x13, valid held → req_ready stays 1, four consecutive WRITE cycles. Then 4 back-to-back reads → rsp_valid high 4 consecutive cycles returning 0x10,0x11,0x12,0x13 in order.
- Alternate read 5 / write 5←0xAA / read 5 → TURN before each direction change. Responses are the prior value, then 0xAA. Bench asserts no cycle has mem_we & mem_oe, and no cycle where both sides drive mem_data.
- Accept a read after a write (enters TURN), pull rst_n low during TURN → no READ cycle, no rsp_valid, all controls 0 afterwards.
- Boundaries: write 0x3FF←0xFF and 0x000←0x00, read both back → 0xFF, 0x00. No aliasing.
